// File: rtl/mult_pp_sequencer.sv
// mult_pp_sequencer: iterative 32x32 multiply front end.
// Feeds four 16x16 unsigned partial products through one registered
// multiplier, accumulates them into a 64-bit sum, applies the signed
// correction to the high word and returns MUL / MULXSS / MULXSU / MULXUU.
//
// Handshake rules (both ports): a transfer happens on a rising edge where
// valid && ready are both high. req_ready is high only in IDLE. rsp_valid is
// high only in RESP, and rsp_result is held stable until it is accepted. No
// request is taken in the same cycle a response is accepted.
module mult_pp_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic [1:0]  op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        busy
);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXSS = 2'b01;
  localparam logic [1:0] OP_MULXSU = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_ACC   = 3'd2,
    ST_FIX   = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [1:0]  op_q;
  logic [1:0]  idx;
  logic [63:0] acc;
  logic [31:0] pp_q;
  logic        pp_valid;
  logic [1:0]  pp_sel;
  logic [31:0] result_q;

  logic        accept;
  logic        issue_en;
  logic        fix_en;
  logic        last_issue;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [63:0] pp_shifted;
  logic        sign_a;
  logic        sign_b;
  logic [31:0] corr;
  logic [31:0] hi_fixed;

  // MUL only needs ll, lh and hl; the hh slice only touches the high word.
  assign last_issue = (op_q == OP_MUL) ? (idx == 2'd2) : (idx == 2'd3);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (req_valid) state_next = ST_ISSUE;
      ST_ISSUE: if (last_issue) state_next = ST_ACC;
      ST_ACC:   state_next = ST_FIX;
      ST_FIX:   state_next = ST_RESP;
      ST_RESP:  if (rsp_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Moore outputs and datapath enables decoded from the state.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    issue_en  = 1'b0;
    fix_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_ISSUE: issue_en  = 1'b1;
      ST_FIX:   fix_en    = 1'b1;
      ST_RESP:  rsp_valid = 1'b1;
      default:  ;
    endcase
  end

  assign accept = req_valid && req_ready;

  // Slice select: idx[1] picks the A half, idx[0] picks the B half.
  assign mul_a = idx[1] ? a_q[31:16] : a_q[15:0];
  assign mul_b = idx[0] ? b_q[31:16] : b_q[15:0];

  // Weight the registered product by its slice position.
  always_comb begin
    pp_shifted = {32'd0, pp_q};
    case (pp_sel)
      2'd0:    pp_shifted = {32'd0, pp_q};
      2'd1,
      2'd2:    pp_shifted = {16'd0, pp_q, 16'd0};
      default: pp_shifted = {pp_q, 32'd0};
    endcase
  end

  // Signed correction subtracted from the high word of the unsigned product.
  assign sign_a   = a_q[31] && ((op_q == OP_MULXSS) || (op_q == OP_MULXSU));
  assign sign_b   = b_q[31] && (op_q == OP_MULXSS);
  assign corr     = (sign_a ? b_q : 32'd0) + (sign_b ? a_q : 32'd0);
  assign hi_fixed = acc[63:32] - corr;

  // Operand capture and issue index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q  <= 32'd0;
      b_q  <= 32'd0;
      op_q <= 2'd0;
      idx  <= 2'd0;
    end else if (accept) begin
      a_q  <= src1;
      b_q  <= src2;
      op_q <= op;
      idx  <= 2'd0;
    end else if (issue_en) begin
      idx <= idx + 2'd1;
    end
  end

  // Single-stage 16x16 multiplier; product and its slice tag land together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pp_q     <= 32'd0;
      pp_valid <= 1'b0;
      pp_sel   <= 2'd0;
    end else begin
      pp_q     <= mul_a * mul_b;
      pp_valid <= issue_en;
      pp_sel   <= idx;
    end
  end

  // Accumulator: cleared on acceptance so nothing stale leaks into a new op.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      acc <= 64'd0;
    else if (accept)   acc <= 64'd0;
    else if (pp_valid) acc <= acc + pp_shifted;
  end

  // Result register, loaded in FIX and held through RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    result_q <= 32'd0;
    else if (fix_en) result_q <= (op_q == OP_MUL) ? acc[31:0] : hi_fixed;
  end

  assign rsp_result = result_q;

endmodule

// File: tb/tb_mult_pp_sequencer.sv
// Directed bench for mult_pp_sequencer: reset values, every opcode with
// hand-computed products, response latency, reset during ISSUE and
// response back-pressure with a queued request.
module tb_mult_pp_sequencer;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [1:0]  op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        busy;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  logic [31:0] exp_q[$];

  mult_pp_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .src1       (src1),
    .src2       (src2),
    .op         (op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .busy       (busy)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request at the next falling edge; returns with the bench at T+1.
  task automatic send_req(input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] o, input logic [31:0] exp);
    @(negedge clk);
    check("req_ready before request", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    src1      = a;
    src2      = b;
    op        = o;
    exp_q.push_back(exp);
    @(negedge clk);
    req_valid = 1'b0;
    src1      = $urandom;
    src2      = $urandom;
    op        = 2'($urandom_range(0, 3));
    check("busy after accept", {31'd0, busy}, 32'd1);
  endtask

  // Wait (bounded) for rsp_valid starting at T+1; lat counts from T.
  task automatic wait_rsp(input string tag, output int lat);
    lat = 1;
    while (!rsp_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) begin
      check({tag, " response timeout"}, 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end
  endtask

  // Full operation with rsp_ready already high: latency, result, recovery.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] o, input logic [31:0] exp);
    int lat;
    int exp_lat;
    logic [31:0] e;
    exp_lat = (o == 2'b00) ? 6 : 7;
    send_req(a, b, o, exp);
    wait_rsp(tag, lat);
    if (rsp_valid) begin
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      e = exp_q.pop_front();
      check({tag, " result"}, rsp_result, e);
      @(negedge clk);
      check({tag, " req_ready after response"}, {31'd0, req_ready}, 32'd1);
      check({tag, " rsp_valid after response"}, {31'd0, rsp_valid}, 32'd0);
    end
  endtask

  initial begin
    int lat;
    logic [31:0] held;
    logic [31:0] e;

    reset_n   = 1'b0;
    req_valid = 1'b0;
    src1      = 32'd0;
    src2      = 32'd0;
    op        = 2'd0;
    rsp_ready = 1'b1;

    #1;
    check("reset req_ready", {31'd0, req_ready}, 32'd1);
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset rsp_result", rsp_result, 32'h0000_0000);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    run_op("mul small",      32'h0001_0003, 32'h0002_0005, 2'b00, 32'h000B_000F);
    run_op("mulxuu small",   32'h0001_0003, 32'h0002_0005, 2'b11, 32'h0000_0002);
    run_op("mulxuu ones",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'hFFFF_FFFE);
    run_op("mulxss ones",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 32'h0000_0000);
    run_op("mulxss minmin",  32'h8000_0000, 32'h8000_0000, 2'b01, 32'h4000_0000);
    run_op("mulxss min1",    32'h8000_0000, 32'h0000_0001, 2'b01, 32'hFFFF_FFFF);
    run_op("mulxsu ones",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 32'hFFFF_FFFF);
    run_op("mulxsu maxneg",  32'h7FFF_FFFF, 32'hFFFF_FFFF, 2'b10, 32'h7FFF_FFFE);
    run_op("mul ones",       32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'h0000_0001);

    // Reset in the middle of ISSUE: immediate return to reset values.
    send_req(32'h1234_5678, 32'h9ABC_DEF0, 2'b11, 32'h0);
    void'(exp_q.pop_front());
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midop reset req_ready", {31'd0, req_ready}, 32'd1);
    check("midop reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midop reset busy", {31'd0, busy}, 32'd0);
    check("midop reset rsp_result", rsp_result, 32'h0000_0000);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check("no response after reset", {31'd0, rsp_valid}, 32'd0);
    run_op("mul after reset", 32'h0001_0003, 32'h0002_0005, 2'b00, 32'h000B_000F);

    // Back-pressure with a second request waiting at the port.
    rsp_ready = 1'b0;
    send_req(32'h0000_0010, 32'h0000_0020, 2'b00, 32'h0000_0200);
    wait_rsp("bp", lat);
    if (rsp_valid) begin
      e = exp_q.pop_front();
      check("bp result", rsp_result, e);
      held = rsp_result;
      req_valid = 1'b1;
      op        = 2'b11;
      src2      = 32'h0000_0003;
      for (int i = 0; i < 5; i++) begin
        src1 = 32'h0003_0000 + 32'(i);
        @(negedge clk);
        check("bp rsp_valid held", {31'd0, rsp_valid}, 32'd1);
        check("bp rsp_result held", rsp_result, held);
        check("bp req_ready low", {31'd0, req_ready}, 32'd0);
      end
      // Queued request: 0x00030000 * 3 = 0x90000, high word 0.
      src1 = 32'h0003_0000;
      exp_q.push_back(32'h0000_0000);
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp idle after handshake", {31'd0, busy}, 32'd0);
      check("bp rsp_valid dropped", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      req_valid = 1'b0;
      check("bp queued accepted", {31'd0, busy}, 32'd1);
      wait_rsp("bp queued", lat);
      if (rsp_valid) begin
        check("bp queued latency", 32'(lat), 32'd7);
        e = exp_q.pop_front();
        check("bp queued result", rsp_result, e);
      end
    end
    @(negedge clk);

    // Final report.
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
